// File: rtl/debounce_pkg.sv
// Shared types and defaults for the two-channel push-button debouncer.
// Imported by the channel sub-module and the top.
package debounce_pkg;

    typedef enum logic [1:0] {
        STABLE_LOW,
        WAIT_HIGH,
        STABLE_HIGH,
        WAIT_LOW
    } db_state_t;

    typedef struct packed {
        logic lvl;
        logic rise;
        logic fall;
    } db_out_t;

    localparam int DEF_DEBOUNCE_CYCLES = 1_000_000;
    localparam int DEF_SYNC_STAGES     = 2;

    function automatic int cnt_width(input int cycles);
        return $clog2(cycles + 1);
    endfunction

endpackage

// File: rtl/debounce_channel.sv
// One debounced channel: input synchronizer, stability counter,
// four-state acceptance FSM and registered rise/fall pulses.
module debounce_channel
    import debounce_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int SYNC_STAGES     = DEF_SYNC_STAGES
) (
    input  logic    clk,
    input  logic    rst,
    input  logic    i_raw,
    output db_out_t o_db
);

    localparam int CW = cnt_width(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   w_s;

    db_state_t     r_state;
    db_state_t     w_state_nxt;
    logic [CW-1:0] r_cnt;
    logic [CW-1:0] w_cnt_nxt;
    logic          r_out;
    logic          w_out_nxt;
    logic          r_rise;
    logic          w_rise_nxt;
    logic          r_fall;
    logic          w_fall_nxt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync <= '0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], i_raw};
        end
    end

    assign w_s = r_sync[SYNC_STAGES-1];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= STABLE_LOW;
            r_cnt   <= '0;
            r_out   <= 1'b0;
            r_rise  <= 1'b0;
            r_fall  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_out   <= w_out_nxt;
            r_rise  <= w_rise_nxt;
            r_fall  <= w_fall_nxt;
        end
    end

    // A single-cycle debounce skips the WAIT states entirely.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = '0;
        w_out_nxt   = r_out;
        w_rise_nxt  = 1'b0;
        w_fall_nxt  = 1'b0;
        unique case (r_state)
            STABLE_LOW: begin
                if (w_s) begin
                    if (CNT_LAST == '0) begin
                        w_state_nxt = STABLE_HIGH;
                        w_out_nxt   = 1'b1;
                        w_rise_nxt  = 1'b1;
                    end else begin
                        w_state_nxt = WAIT_HIGH;
                        w_cnt_nxt   = CNT_ONE;
                    end
                end
            end
            WAIT_HIGH: begin
                if (!w_s) begin
                    w_state_nxt = STABLE_LOW;
                end else if (r_cnt == CNT_LAST) begin
                    w_state_nxt = STABLE_HIGH;
                    w_out_nxt   = 1'b1;
                    w_rise_nxt  = 1'b1;
                end else begin
                    w_cnt_nxt = r_cnt + CNT_ONE;
                end
            end
            STABLE_HIGH: begin
                if (!w_s) begin
                    if (CNT_LAST == '0) begin
                        w_state_nxt = STABLE_LOW;
                        w_out_nxt   = 1'b0;
                        w_fall_nxt  = 1'b1;
                    end else begin
                        w_state_nxt = WAIT_LOW;
                        w_cnt_nxt   = CNT_ONE;
                    end
                end
            end
            WAIT_LOW: begin
                if (w_s) begin
                    w_state_nxt = STABLE_HIGH;
                end else if (r_cnt == CNT_LAST) begin
                    w_state_nxt = STABLE_LOW;
                    w_out_nxt   = 1'b0;
                    w_fall_nxt  = 1'b1;
                end else begin
                    w_cnt_nxt = r_cnt + CNT_ONE;
                end
            end
        endcase
    end

    assign o_db.lvl  = r_out;
    assign o_db.rise = r_rise;
    assign o_db.fall = r_fall;

endmodule

// File: rtl/dual_button_debouncer.sv
// Two independent debounced button channels feeding the gate stage.
// Holds only the channel wiring and parameter sanity checks.
module dual_button_debouncer
    import debounce_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int SYNC_STAGES     = DEF_SYNC_STAGES
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_a_raw,
    input  logic btn_b_raw,
    output logic a,
    output logic b,
    output logic a_rise,
    output logic a_fall,
    output logic b_rise,
    output logic b_fall
);

    if (DEBOUNCE_CYCLES < 1) begin : g_bad_debounce
        $error("DEBOUNCE_CYCLES must be >= 1");
    end

    if (SYNC_STAGES < 2) begin : g_bad_sync
        $error("SYNC_STAGES must be >= 2");
    end

    db_out_t w_a_db;
    db_out_t w_b_db;

    debounce_channel #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .SYNC_STAGES     (SYNC_STAGES)
    ) u_ch_a (
        .clk   (clk),
        .rst   (rst),
        .i_raw (btn_a_raw),
        .o_db  (w_a_db)
    );

    debounce_channel #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .SYNC_STAGES     (SYNC_STAGES)
    ) u_ch_b (
        .clk   (clk),
        .rst   (rst),
        .i_raw (btn_b_raw),
        .o_db  (w_b_db)
    );

    assign a      = w_a_db.lvl;
    assign a_rise = w_a_db.rise;
    assign a_fall = w_a_db.fall;
    assign b      = w_b_db.lvl;
    assign b_rise = w_b_db.rise;
    assign b_fall = w_b_db.fall;

endmodule

// File: tb/tb_dual_button_debouncer.sv
// Scoreboard bench: run-length reference model vs. dual_button_debouncer.
module tb_dual_button_debouncer;

    localparam int DEB  = 4;
    localparam int SYNC = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic btn_a_raw = 1'b0;
    logic btn_b_raw = 1'b0;
    logic a, b, a_rise, a_fall, b_rise, b_fall;

    int n_vec = 0;
    int n_err = 0;
    logic [5:0] exp_q[$];

    dual_button_debouncer #(
        .DEBOUNCE_CYCLES (DEB),
        .SYNC_STAGES     (SYNC)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .btn_a_raw (btn_a_raw),
        .btn_b_raw (btn_b_raw),
        .a         (a),
        .b         (b),
        .a_rise    (a_rise),
        .a_fall    (a_fall),
        .b_rise    (b_rise),
        .b_fall    (b_fall)
    );

    always #5 clk = ~clk;

    function automatic logic [5:0] dut_out();
        return {a, b, a_rise, a_fall, b_rise, b_fall};
    endfunction

    function automatic logic [2:0] ch_bits(input int ch);
        if (ch == 0) return {a, a_rise, a_fall};
        return {b, b_rise, b_fall};
    endfunction

    task automatic chk(input string nm, input logic [5:0] act,
                       input logic [5:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s @%0t: got %b expected %b", nm, $time, act, exp);
        end
    endtask

    // Reference: output flips once the synchronized input has disagreed
    // with it for DEB consecutive sampled cycles.
    task automatic ref_step(input bit s, inout bit lvl, inout int run,
                            output bit rise, output bit fall);
        rise = 1'b0;
        fall = 1'b0;
        if (s != lvl) begin
            run++;
            if (run == DEB) begin
                lvl  = s;
                rise = s;
                fall = !s;
                run  = 0;
            end
        end else begin
            run = 0;
        end
    endtask

    initial begin : model
        bit oa, ob, sa, sb, ra_p, fa_p, rb_p, fb_p;
        int runa, runb;
        bit ha[$];
        bit hb[$];
        oa = 0; ob = 0; runa = 0; runb = 0;
        forever begin
            @(posedge clk);
            if (rst) begin
                oa = 0; ob = 0; runa = 0; runb = 0;
                ha = {}; hb = {};
                repeat (SYNC) begin
                    ha.push_back(1'b0);
                    hb.push_back(1'b0);
                end
                exp_q.push_back(6'b0);
            end else begin
                sa = ha.pop_front();
                sb = hb.pop_front();
                ha.push_back(btn_a_raw);
                hb.push_back(btn_b_raw);
                ref_step(sa, oa, runa, ra_p, fa_p);
                ref_step(sb, ob, runb, rb_p, fb_p);
                exp_q.push_back({oa, ob, ra_p, fa_p, rb_p, fb_p});
            end
        end
    end

    initial begin : monitor
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL sb_empty @%0t: got %b expected entry",
                         $time, dut_out());
            end else begin
                chk("sb", dut_out(), exp_q.pop_front());
            end
        end
    end

    task automatic drive(input bit ra, input bit rb);
        @(negedge clk);
        btn_a_raw = ra;
        btn_b_raw = rb;
    endtask

    // Called just after the input change; next posedge is edge 1.
    task automatic expect_change(input string nm, input int ch, input bit lvl);
        logic [2:0] v;
        repeat (SYNC + DEB - 1) @(posedge clk);
        #1;
        v = ch_bits(ch);
        chk({nm, "_early"}, {5'b0, v[2]}, {5'b0, !lvl});
        @(posedge clk);
        #1;
        chk(nm, {3'b0, ch_bits(ch)}, {3'b0, lvl, lvl, !lvl});
        @(posedge clk);
        #1;
        chk({nm, "_once"}, {3'b0, ch_bits(ch)}, {3'b0, lvl, 2'b00});
    endtask

    initial begin : stim
        int la, lb;
        rst = 1'b1;
        for (int i = 0; i < 3; i++) drive(i[0], !i[0]);

        @(negedge clk);
        rst = 1'b0;
        btn_a_raw = 1'b1;
        btn_b_raw = 1'b0;
        expect_change("t2_rise", 0, 1'b1);

        drive(1'b0, 1'b0);
        expect_change("t4_fall", 0, 1'b0);

        drive(1'b1, 1'b0);
        repeat (2) @(negedge clk);
        drive(1'b0, 1'b0);
        repeat (6) @(negedge clk);
        drive(1'b1, 1'b0);
        expect_change("t3_rise", 0, 1'b1);

        drive(1'b0, 1'b0);
        repeat (8) @(negedge clk);
        drive(1'b1, 1'b1);
        repeat (SYNC + DEB) @(posedge clk);
        #1;
        chk("t5_both", {2'b0, a, b, a_rise, b_rise}, 6'b001111);

        @(negedge clk);
        rst = 1'b1;
        btn_a_raw = 1'b0;
        btn_b_raw = 1'b0;
        #1;
        chk("rst_async", dut_out(), 6'b0);
        @(negedge clk);
        rst = 1'b0;

        drive(1'b1, 1'b0);
        repeat (SYNC + 2) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("t6_rst", dut_out(), 6'b0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        expect_change("t6_rise", 0, 1'b1);

        la = 0;
        lb = 0;
        for (int i = 0; i < 500; i++) begin
            @(negedge clk);
            if ($urandom_range(0, 99) == 0) begin
                rst = 1'b1;
                #1;
                chk("rnd_rst", dut_out(), 6'b0);
            end else begin
                rst = 1'b0;
            end
            if (la == 0) begin
                btn_a_raw = 1'($urandom_range(0, 1));
                la = $urandom_range(1, 8);
            end
            if (lb == 0) begin
                btn_b_raw = 1'($urandom_range(0, 1));
                lb = $urandom_range(1, 8);
            end
            la--;
            lb--;
        end

        @(negedge clk);
        rst = 1'b0;
        repeat (12) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
